// File: rtl/fwd_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
//   Bundles every signal exchanged between the pipeline datapath and the
//   forwarding/hazard controller.
//
//   master : pipeline side (drives stage information, consumes controls)
//   slave  : controller side (consumes stage information, drives controls)
//
//   Pipeline -> controller
//     id_src, ex_src   NREAD packed source register addresses of ID / EX instr
//     ex_wen, ex_rd    EX instr writes regfile / its destination
//     ex_load          EX instr is a load
//     mem_wen, mem_rd  MEM instr writes regfile / its destination
//     mem_load         MEM instr is a load
//     dhit             dcache data valid this cycle
//     mem_dreq         MEM instr accesses dcache
//     wb_wen, wb_rd    WB instr writes regfile / its destination
//   Controller -> pipeline
//     fwd_ex           2-bit EX operand mux select per operand
//     fwd_id           ID regfile bypass of WB result per operand
//     stall_ifid       hold PC and IF/ID
//     flush_idex       insert bubble into ID/EX
//     freeze           hold every pipeline register
//     stall_cnt        count of cycles with stall_ifid or freeze asserted
// -----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int NREAD = 2,
  parameter int CNT_W = 32
);

  logic [NREAD*REG_W-1:0] id_src;
  logic [NREAD*REG_W-1:0] ex_src;
  logic                   ex_wen;
  logic [REG_W-1:0]       ex_rd;
  logic                   ex_load;
  logic                   mem_wen;
  logic [REG_W-1:0]       mem_rd;
  logic                   mem_load;
  logic                   dhit;
  logic                   mem_dreq;
  logic                   wb_wen;
  logic [REG_W-1:0]       wb_rd;

  logic [NREAD*2-1:0]     fwd_ex;
  logic [NREAD-1:0]       fwd_id;
  logic                   stall_ifid;
  logic                   flush_idex;
  logic                   freeze;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output id_src, ex_src, ex_wen, ex_rd, ex_load,
           mem_wen, mem_rd, mem_load, dhit, mem_dreq,
           wb_wen, wb_rd,
    input  fwd_ex, fwd_id, stall_ifid, flush_idex, freeze, stall_cnt
  );

  modport slave (
    input  id_src, ex_src, ex_wen, ex_rd, ex_load,
           mem_wen, mem_rd, mem_load, dhit, mem_dreq,
           wb_wen, wb_rd,
    output fwd_ex, fwd_id, stall_ifid, flush_idex, freeze, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding and hazard controller for a 5-stage pipeline.
//   - Combinational EX operand forwarding (MEM result wins over WB result)
//     and ID regfile bypass of the WB result, for NREAD source operands.
//   - Load-use interlock inserting LU_BUB bubbles.
//   - Data-cache miss freeze of the whole pipeline; a miss that lands in the
//     middle of a load-use bubble sequence suspends it and the remaining
//     bubbles resume once the miss is serviced.
//   - Free-running, wrapping stall-cycle performance counter.
//
// Parameters
//   REG_W   register address width
//   NREAD   source operands per instruction (1..4)
//   LU_BUB  load-use bubbles inserted (1..3)
//   CNT_W   stall counter width
//
// Ports
//   CLK     rising-edge clock
//   nRST    asynchronous active-low reset; every output reads 0 while low
//   bus     controller side of fwd_hazard_ctrl_if (see interface header)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int NREAD  = 2,
  parameter int LU_BUB = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  fwd_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUBBLE  = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  // Bubbles still owed after the current one, loaded when the first bubble
  // is issued from RUN. With LU_BUB <= 3 two bits are always enough.
  localparam logic [1:0] BUB_INIT = (LU_BUB > 1) ? 2'(LU_BUB - 2) : 2'd0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  state_t           state, state_n;
  logic [1:0]       bub_cnt, bub_cnt_n;
  logic             resume, resume_n;
  logic [CNT_W-1:0] stall_cnt;

  logic [NREAD*2-1:0] fwd_ex_c;
  logic [NREAD-1:0]   fwd_id_c;
  logic               lu_hit;
  logic               miss;
  logic               stall_c;
  logic               flush_c;
  logic               freeze_c;

  // mem_load is carried on the bus for the pipeline's benefit; the MEM-stage
  // load result is forwarded exactly like any other MEM result.
  logic unused_inputs;
  assign unused_inputs = bus.mem_load;

  // ---------------------------------------------------------------------------
  // Forwarding and load-use detection
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in this block gets a default first, so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    logic [REG_W-1:0] src_ex;
    logic [REG_W-1:0] src_id;
    fwd_ex_c = '0;
    fwd_id_c = '0;
    lu_hit   = 1'b0;
    src_ex   = '0;
    src_id   = '0;
    for (int k = 0; k < NREAD; k++) begin
      src_ex = bus.ex_src[k*REG_W +: REG_W];
      src_id = bus.id_src[k*REG_W +: REG_W];

      // Register 0 is hard-wired; it never needs a bypass.
      if (src_ex != '0) begin
        if (bus.mem_wen && (bus.mem_rd == src_ex)) begin
          fwd_ex_c[2*k +: 2] = FWD_MEM;
        end else if (bus.wb_wen && (bus.wb_rd == src_ex)) begin
          fwd_ex_c[2*k +: 2] = FWD_WB;
        end else begin
          fwd_ex_c[2*k +: 2] = FWD_RF;
        end
      end

      if (bus.wb_wen && (bus.wb_rd != '0) && (bus.wb_rd == src_id)) begin
        fwd_id_c[k] = 1'b1;
      end

      if (src_id == bus.ex_rd) begin
        lu_hit = 1'b1;
      end
    end
    lu_hit = lu_hit && bus.ex_load && bus.ex_wen && (bus.ex_rd != '0);
  end

  assign miss = bus.mem_dreq && !bus.dhit;

  // ---------------------------------------------------------------------------
  // Hazard FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      bub_cnt <= 2'd0;
      resume  <= 1'b0;
    end else begin
      state   <= state_n;
      bub_cnt <= bub_cnt_n;
      resume  <= resume_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard FSM: next state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    bub_cnt_n = bub_cnt;
    resume_n  = resume;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    freeze_c  = 1'b0;

    unique case (state)
      RUN: begin
        // A cache miss outranks the interlock: nothing may move while the
        // dcache is busy, and the load-use case re-evaluates afterwards.
        if (miss) begin
          freeze_c = 1'b1;
          resume_n = 1'b0;
          state_n  = MEMWAIT;
        end else if (lu_hit) begin
          stall_c = 1'b1;
          flush_c = 1'b1;
          if (LU_BUB > 1) begin
            bub_cnt_n = BUB_INIT;
            state_n   = BUBBLE;
          end
        end
      end

      BUBBLE: begin
        // A miss here suspends the sequence: the bubble for this cycle is not
        // issued and bub_cnt is held so the full remainder replays later.
        if (miss) begin
          freeze_c = 1'b1;
          resume_n = 1'b1;
          state_n  = MEMWAIT;
        end else begin
          stall_c = 1'b1;
          flush_c = 1'b1;
          if (bub_cnt == 2'd0) begin
            state_n = RUN;
          end else begin
            bub_cnt_n = bub_cnt - 2'd1;
          end
        end
      end

      MEMWAIT: begin
        // Freeze drops in the same cycle the data arrives.
        if (bus.dhit) begin
          state_n  = resume ? BUBBLE : RUN;
          resume_n = 1'b0;
        end else begin
          freeze_c = 1'b1;
        end
      end

      default: begin
        state_n = RUN;
      end
    endcase

    // Never push a bubble into registers that are being held.
    if (freeze_c) begin
      flush_c = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall-cycle performance counter (wraps, no saturation)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (stall_c || freeze_c) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: forced low for as long as reset is held, regardless of inputs.
  // ---------------------------------------------------------------------------
  assign bus.fwd_ex     = nRST ? fwd_ex_c : '0;
  assign bus.fwd_id     = nRST ? fwd_id_c : '0;
  assign bus.stall_ifid = nRST && stall_c;
  assign bus.flush_idex = nRST && flush_c;
  assign bus.freeze     = nRST && freeze_c;
  assign bus.stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Drives two controllers from one stimulus stream:
//     dut_a : LU_BUB=1, CNT_W=32
//     dut_b : LU_BUB=3, CNT_W=4
//   A reference model describes the controller as "bubbles still owed" plus
//   "waiting on the dcache", and counts stall cycles as a plain integer.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int NREAD = 2;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [NREAD*REG_W-1:0] id_src, ex_src;
  logic                   ex_wen, ex_load, mem_wen, mem_load, dhit, mem_dreq, wb_wen;
  logic [REG_W-1:0]       ex_rd, mem_rd, wb_rd;

  fwd_hazard_ctrl_if #(.REG_W(REG_W), .NREAD(NREAD), .CNT_W(32)) bus_a ();
  fwd_hazard_ctrl_if #(.REG_W(REG_W), .NREAD(NREAD), .CNT_W(4))  bus_b ();

  assign bus_a.id_src   = id_src;    assign bus_b.id_src   = id_src;
  assign bus_a.ex_src   = ex_src;    assign bus_b.ex_src   = ex_src;
  assign bus_a.ex_wen   = ex_wen;    assign bus_b.ex_wen   = ex_wen;
  assign bus_a.ex_rd    = ex_rd;     assign bus_b.ex_rd    = ex_rd;
  assign bus_a.ex_load  = ex_load;   assign bus_b.ex_load  = ex_load;
  assign bus_a.mem_wen  = mem_wen;   assign bus_b.mem_wen  = mem_wen;
  assign bus_a.mem_rd   = mem_rd;    assign bus_b.mem_rd   = mem_rd;
  assign bus_a.mem_load = mem_load;  assign bus_b.mem_load = mem_load;
  assign bus_a.dhit     = dhit;      assign bus_b.dhit     = dhit;
  assign bus_a.mem_dreq = mem_dreq;  assign bus_b.mem_dreq = mem_dreq;
  assign bus_a.wb_wen   = wb_wen;    assign bus_b.wb_wen   = wb_wen;
  assign bus_a.wb_rd    = wb_rd;     assign bus_b.wb_rd    = wb_rd;

  fwd_hazard_ctrl #(.REG_W(REG_W), .NREAD(NREAD), .LU_BUB(1), .CNT_W(32)) dut_a (
    .CLK(CLK), .nRST(nRST), .bus(bus_a)
  );
  fwd_hazard_ctrl #(.REG_W(REG_W), .NREAD(NREAD), .LU_BUB(3), .CNT_W(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .bus(bus_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state (index 0 = dut_a, 1 = dut_b)
  // ---------------------------------------------------------------------------
  int     lub[2] = '{1, 3};
  int     cw[2]  = '{32, 4};
  int     owed[2];      // load-use bubbles still to be inserted
  bit     waiting[2];   // dcache miss outstanding
  longint cycles[2];    // stall/freeze cycles since reset

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owed[i] = 0; waiting[i] = 0; cycles[i] = 0;
    end
  endtask

  function automatic longint wrap(input int i);
    return cycles[i] % (longint'(1) << cw[i]);
  endfunction

  // ---------------------------------------------------------------------------
  // One clock: predict at negedge, compare, advance the model at posedge.
  // Inputs are expected to be set shortly after the previous posedge.
  // ---------------------------------------------------------------------------
  task automatic step();
    logic [2*NREAD-1:0] e_ex;
    logic [NREAD-1:0]   e_id;
    logic [REG_W-1:0]   s;
    bit lu, miss;
    bit st[2], fr[2], n_wait[2];
    int n_owed[2];

    @(negedge CLK);
    e_ex = '0; e_id = '0; lu = 0;
    for (int k = 0; k < NREAD; k++) begin
      s = ex_src[k*REG_W +: REG_W];
      if (s != 0 && mem_wen && mem_rd == s)     e_ex[2*k +: 2] = 2'b01;
      else if (s != 0 && wb_wen && wb_rd == s)  e_ex[2*k +: 2] = 2'b10;
      s = id_src[k*REG_W +: REG_W];
      if (s != 0 && wb_wen && wb_rd == s) e_id[k] = 1'b1;
      if (ex_load && ex_wen && ex_rd != 0 && s == ex_rd) lu = 1;
    end
    miss = mem_dreq && !dhit;

    for (int i = 0; i < 2; i++) begin
      st[i] = 0; fr[i] = 0; n_owed[i] = owed[i]; n_wait[i] = waiting[i];
      if (waiting[i]) begin
        fr[i] = !dhit;
        if (dhit) n_wait[i] = 0;
      end else if (miss) begin
        fr[i] = 1; n_wait[i] = 1;
      end else if (owed[i] > 0) begin
        st[i] = 1; n_owed[i] = owed[i] - 1;
      end else if (lu) begin
        st[i] = 1; n_owed[i] = lub[i] - 1;
      end
    end

    check("a_fwd_ex", bus_a.fwd_ex,     e_ex);
    check("a_fwd_id", bus_a.fwd_id,     e_id);
    check("a_stall",  bus_a.stall_ifid, st[0]);
    check("a_flush",  bus_a.flush_idex, st[0]);
    check("a_freeze", bus_a.freeze,     fr[0]);
    check("a_cnt",    bus_a.stall_cnt,  wrap(0));
    check("b_fwd_ex", bus_b.fwd_ex,     e_ex);
    check("b_fwd_id", bus_b.fwd_id,     e_id);
    check("b_stall",  bus_b.stall_ifid, st[1]);
    check("b_flush",  bus_b.flush_idex, st[1]);
    check("b_freeze", bus_b.freeze,     fr[1]);
    check("b_cnt",    bus_b.stall_cnt,  wrap(1));

    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      owed[i] = n_owed[i]; waiting[i] = n_wait[i];
      if (st[i] || fr[i]) cycles[i]++;
    end
    #1;
  endtask

  task automatic clr();
    id_src = '0; ex_src = '0; ex_wen = 0; ex_rd = '0; ex_load = 0;
    mem_wen = 0; mem_rd = '0; mem_load = 0; dhit = 0; mem_dreq = 0;
    wb_wen = 0; wb_rd = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_fwd_ex"}, bus_a.fwd_ex,     0);
    check({tag, "_a_fwd_id"}, bus_a.fwd_id,     0);
    check({tag, "_a_stall"},  bus_a.stall_ifid, 0);
    check({tag, "_a_flush"},  bus_a.flush_idex, 0);
    check({tag, "_a_freeze"}, bus_a.freeze,     0);
    check({tag, "_a_cnt"},    bus_a.stall_cnt,  0);
    check({tag, "_b_fwd_ex"}, bus_b.fwd_ex,     0);
    check({tag, "_b_fwd_id"}, bus_b.fwd_id,     0);
    check({tag, "_b_stall"},  bus_b.stall_ifid, 0);
    check({tag, "_b_flush"},  bus_b.flush_idex, 0);
    check({tag, "_b_freeze"}, bus_b.freeze,     0);
    check({tag, "_b_cnt"},    bus_b.stall_cnt,  0);
  endtask

  // Inputs that would light up every output if reset were not asserted.
  task automatic busy_inputs();
    mem_wen = 1; mem_rd = 5'd5; wb_wen = 1; wb_rd = 5'd6;
    ex_src = {5'd5, 5'd6}; id_src = {5'd6, 5'd8};
    ex_load = 1; ex_wen = 1; ex_rd = 5'd8; mem_dreq = 1; dhit = 0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < NREAD; k++) begin
      id_src[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 4));
      ex_src[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 4));
    end
    ex_wen   = ($urandom_range(0, 3) != 0);
    ex_rd    = REG_W'($urandom_range(0, 4));
    ex_load  = ($urandom_range(0, 2) == 0);
    mem_wen  = $urandom_range(0, 1) == 1;
    mem_rd   = REG_W'($urandom_range(0, 4));
    mem_load = $urandom_range(0, 1) == 1;
    mem_dreq = ($urandom_range(0, 3) == 0);
    dhit     = $urandom_range(0, 1) == 1;
    wb_wen   = $urandom_range(0, 1) == 1;
    wb_rd    = REG_W'($urandom_range(0, 4));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    clr();
    busy_inputs();
    nRST = 1'b0;
    #3;
    check_zero("rst");
    #9;
    nRST = 1'b1;
    clr();
    model_reset();
    @(posedge CLK);
    #1;

    // Forwarding priority: MEM beats WB, register 0 never forwards.
    mem_wen = 1; wb_wen = 1; mem_rd = 5'd5; wb_rd = 5'd5; ex_src = {5'd5, 5'd5};
    #1 check("fwd_mem_wins", bus_a.fwd_ex, 4'b0101);
    step();
    mem_wen = 0;
    #1 check("fwd_wb", bus_a.fwd_ex, 4'b1010);
    step();
    ex_src = '0;
    #1 check("fwd_src0", bus_a.fwd_ex, 4'b0000);
    step();
    id_src = {5'd5, 5'd0};
    #1 check("fwd_id_bypass", bus_a.fwd_id, 2'b10);
    step();

    // Load-use: one bubble on dut_a, three on dut_b.
    clr(); do_reset();
    ex_load = 1; ex_wen = 1; ex_rd = 5'd8; id_src = {5'd8, 5'd3};
    #1 check("lu_stall_a", bus_a.stall_ifid, 1'b1);
    step();
    clr();
    for (int c = 0; c < 4; c++) step();
    check("lu1_cnt_a", bus_a.stall_cnt, 1);
    check("lu3_cnt_b", bus_b.stall_cnt, 3);

    // Dcache miss: four frozen cycles, freeze drops on the hit cycle.
    clr(); do_reset();
    mem_dreq = 1; dhit = 0;
    for (int c = 0; c < 4; c++) step();
    dhit = 1;
    #1 check("miss_hit_freeze", bus_a.freeze, 1'b0);
    step();
    clr();
    step();
    check("miss_cnt_a", bus_a.stall_cnt, 4);

    // Miss arriving on the second load-use bubble of dut_b.
    clr(); do_reset();
    ex_load = 1; ex_wen = 1; ex_rd = 5'd8; id_src = {5'd8, 5'd0};
    step();
    clr();
    mem_dreq = 1; dhit = 0;
    #1 check("bub_miss_flush_b", bus_b.flush_idex, 1'b0);
    step(); step();
    dhit = 1;
    step();
    clr();
    for (int c = 0; c < 3; c++) step();
    check("bub_miss_cnt_b", bus_b.stall_cnt, 5);

    // Counter wrap on the 4-bit instance, then reset while in MEMWAIT.
    clr(); do_reset();
    mem_dreq = 1; dhit = 0;
    for (int c = 0; c < 17; c++) step();
    check("wrap_cnt_b", bus_b.stall_cnt, 1);
    busy_inputs();
    #2 nRST = 1'b0;
    #1 check_zero("rst_memwait");
    #1 nRST = 1'b1;
    model_reset();
    clr();
    @(posedge CLK);
    #1;
    step();
    check("post_rst_freeze", bus_a.freeze, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
